// File: rtl/bike_mult_pkg.sv
// Shared definitions for the BIKE sparse x dense multiplier control slice.
//   mult_state_e  : sweep controller FSM states
//   DENSE_RD_LAT  : dense BRAM read latency in cycles
//   ACC_LAT       : cycles from a dense read to the matching accumulator write
//   DRAIN_CYC     : idle cycles after the last read so in-flight writes retire
package bike_mult_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSweep,
    StDrain,
    StDone
  } mult_state_e;

  localparam int unsigned DENSE_RD_LAT = 1;
  // One extra cycle for the datapath stage behind the dense read.
  localparam int unsigned ACC_LAT      = DENSE_RD_LAT + 1;
  localparam int unsigned DRAIN_CYC    = ACC_LAT;

endpackage

// File: rtl/bike_mult_delay_pipe.sv
// Fixed-depth shift register with asynchronous clear.
// Carries the {we, addr} accumulator command alongside the dense-read/datapath pipeline.
//   clk     : clock
//   resetn  : asynchronous active-low reset, clears every stage
//   data_i  : word entering the pipe
//   data_o  : word leaving the pipe DEPTH cycles later
module bike_mult_delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bike_mult_sweep_ctrl.sv
// Address sequencer for the sparse x dense polynomial multiplier.
// For each of WEIGHT sparse positions: read the position from sparse BRAM, then sweep all
// NUM_WORDS dense words rotated by the position's word index. Accumulator writes follow the
// dense reads ACC_LAT cycles later.
//   clk, resetn            : clock, asynchronous active-low reset
//   start                  : pulse, begins a multiplication when idle
//   sparse_rden/addr       : sparse BRAM read port
//   sparse_word_idx        : sparse read data, valid the cycle after sparse_rden
//   dense_rden/addr        : dense BRAM read port (rotated address)
//   acc_we/acc_addr        : accumulator write command aligned to the datapath result
//   busy, done             : status; done is a single-cycle pulse
//   err                    : sticky out-of-range word index flag, cleared by start
module bike_mult_sweep_ctrl
  import bike_mult_pkg::*;
#(
  parameter int unsigned WEIGHT    = 71,
  parameter int unsigned NUM_WORDS = 12,
  parameter int unsigned LOGW      = 7,
  parameter int unsigned LOGN      = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  output logic            sparse_rden,
  output logic [LOGW-1:0] sparse_addr,
  input  logic [LOGN-1:0] sparse_word_idx,
  output logic            dense_rden,
  output logic [LOGN-1:0] dense_addr,
  output logic            acc_we,
  output logic [LOGN-1:0] acc_addr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [LOGN:0]   NumWordsExt = (LOGN+1)'(NUM_WORDS);
  localparam logic [LOGN-1:0] LastWord    = LOGN'(NUM_WORDS - 1);
  localparam logic [LOGW-1:0] LastPos     = LOGW'(WEIGHT - 1);
  localparam int unsigned     DrainW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DrainW-1:0] LastDrain = DrainW'(DRAIN_CYC - 1);

  mult_state_e       state_q, state_d;
  logic [LOGW-1:0]   pos_cnt_q, pos_cnt_d;
  logic [LOGN-1:0]   word_cnt_q, word_cnt_d;
  logic [LOGN-1:0]   base_q, base_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              err_q, err_d;

  logic sparse_rden_q, sparse_rden_d;
  logic dense_rden_q, dense_rden_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic            idx_oob;
  logic [LOGN:0]   rot_sum;
  logic [LOGN-1:0] rot_addr;
  logic [LOGN:0]   acc_pipe_in, acc_pipe_out;

  assign idx_oob = ({1'b0, sparse_word_idx} >= NumWordsExt);

  // Both operands are < NUM_WORDS, so a single conditional subtract wraps the sum.
  assign rot_sum  = {1'b0, base_q} + {1'b0, word_cnt_q};
  assign rot_addr = (rot_sum >= NumWordsExt) ? LOGN'(rot_sum - NumWordsExt) : LOGN'(rot_sum);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      pos_cnt_q     <= '0;
      word_cnt_q    <= '0;
      base_q        <= '0;
      drain_cnt_q   <= '0;
      err_q         <= 1'b0;
      sparse_rden_q <= 1'b0;
      dense_rden_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_cnt_q     <= pos_cnt_d;
      word_cnt_q    <= word_cnt_d;
      base_q        <= base_d;
      drain_cnt_q   <= drain_cnt_d;
      err_q         <= err_d;
      sparse_rden_q <= sparse_rden_d;
      dense_rden_q  <= dense_rden_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    pos_cnt_d   = pos_cnt_q;
    word_cnt_d  = word_cnt_q;
    base_d      = base_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          pos_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        state_d    = StSweep;
        word_cnt_d = '0;
        if (idx_oob) begin
          err_d  = 1'b1;
          base_d = '0;
        end else begin
          base_d = sparse_word_idx;
        end
      end
      StSweep: begin
        if (word_cnt_q == LastWord) begin
          word_cnt_d = '0;
          if (pos_cnt_q == LastPos) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end else begin
            pos_cnt_d = pos_cnt_q + 1'b1;
            state_d   = StFetch;
          end
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_cnt_q == LastDrain) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each is high exactly while
  // the FSM occupies the matching state.
  always_comb begin
    sparse_rden_d = (state_d == StFetch);
    dense_rden_d  = (state_d == StSweep);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
  end

  assign acc_pipe_in = {dense_rden_q, (dense_rden_q ? word_cnt_q : '0)};

  bike_mult_delay_pipe #(
    .WIDTH (LOGN + 1),
    .DEPTH (ACC_LAT)
  ) u_acc_pipe (
    .clk    (clk),
    .resetn (resetn),
    .data_i (acc_pipe_in),
    .data_o (acc_pipe_out)
  );

  assign sparse_rden = sparse_rden_q;
  assign sparse_addr = sparse_rden_q ? pos_cnt_q : '0;
  assign dense_rden  = dense_rden_q;
  assign dense_addr  = dense_rden_q ? rot_addr : '0;
  assign acc_we      = acc_pipe_out[LOGN];
  assign acc_addr    = acc_pipe_out[LOGN-1:0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
